// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small write FIFO; frames are sent back-to-back while data is queued.
// Baud divisor is sampled per frame, parity and stop-bit count are fixed at build time.
//
// state    | meaning
// S_IDLE   | line idle high, waiting for a queued byte
// S_START  | start bit (low)
// S_DATA   | payload bits, LSB first
// S_PARITY | parity bit (only when PARITY_EN)
// S_STOP   | stop bit(s), high
module uart_tx_fifo #(
    parameter int PAYLOAD_BITS = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int DIV_BITS     = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DIV_BITS-1:0]           clk_div,
    input  logic                          uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0]       uart_tx_data,
    output logic                          uart_tx_ready,
    output logic                          uart_tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          uart_txd
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [PAYLOAD_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [LW-1:0]           r_level;
    logic [2:0]              r_state;
    logic [DIV_BITS-1:0]     r_div;
    logic [DIV_BITS-1:0]     r_cnt;
    logic [3:0]              r_bit_idx;
    logic [PAYLOAD_BITS-1:0] r_shift;
    logic [PAYLOAD_BITS-1:0] r_data;
    logic                    r_txd;

    logic w_push;
    logic w_pop;
    logic w_bit_end;
    logic w_last_stop;

    // ready comes from the registered level only, so a same-edge pop never frees a slot
    assign uart_tx_ready = (r_level != LW'(FIFO_DEPTH));
    assign uart_tx_busy  = (r_level != '0) || (r_state != S_IDLE);
    assign fifo_level    = r_level;
    assign uart_txd      = r_txd;

    assign w_push      = uart_tx_en && uart_tx_ready;
    assign w_bit_end   = (r_state != S_IDLE) && (r_cnt == r_div);
    assign w_last_stop = (r_state == S_STOP) && w_bit_end && (r_bit_idx == 4'(STOP_BITS - 1));
    assign w_pop       = (r_level != '0) && ((r_state == S_IDLE) || w_last_stop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= uart_tx_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= '0;
        end else if (w_pop) begin
            // divisor is sampled only here; mid-frame changes wait for the next frame
            r_shift   <= r_mem[r_rd_ptr];
            r_data    <= r_mem[r_rd_ptr];
            r_div     <= clk_div;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= S_START;
        end else if (w_bit_end) begin
            r_cnt <= '0;
            case (r_state)
                S_START: begin
                    r_bit_idx <= '0;
                    r_state   <= S_DATA;
                end
                S_DATA: begin
                    r_shift <= r_shift >> 1;
                    if (r_bit_idx == 4'(PAYLOAD_BITS - 1)) begin
                        r_bit_idx <= '0;
                        r_state   <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end
                end
                S_PARITY: begin
                    r_bit_idx <= '0;
                    r_state   <= S_STOP;
                end
                S_STOP: begin
                    if (w_last_stop) r_state   <= S_IDLE;
                    else             r_bit_idx <= r_bit_idx + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end else if (r_state != S_IDLE) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_txd <= 1'b1;
        end else begin
            case (r_state)
                S_START:  r_txd <= 1'b0;
                S_DATA:   r_txd <= r_shift[0];
                S_PARITY: r_txd <= (^r_data) ^ (PARITY_ODD != 0);
                default:  r_txd <= 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Three differently configured transmitters share one stimulus stream; each is
// compared every clock against a frame-level model built from queued bytes.
module tb_uart_tx_fifo;
    localparam int NI = 3;
    localparam int PB [NI] = '{8, 7, 8};
    localparam int DP [NI] = '{4, 4, 8};
    localparam int PE [NI] = '{0, 1, 1};
    localparam int PO [NI] = '{0, 1, 0};
    localparam int SB [NI] = '{1, 2, 1};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] clk_div = 16'd0;
    logic        tx_en = 1'b0;
    logic [8:0]  tx_data = 9'd0;

    logic        o_ready [NI];
    logic        o_busy  [NI];
    logic        o_txd   [NI];
    logic [2:0]  lvl0;
    logic [2:0]  lvl1;
    logic [3:0]  lvl2;

    int n_asserts = 0;
    int n_fail = 0;

    int unsigned mq [NI][$];
    bit          m_active [NI];
    int          m_t   [NI];
    int          m_len [NI];
    int          m_nb  [NI];
    bit          m_bits [NI][16];
    bit          m_txd  [NI];

    always #5 clk = ~clk;

    uart_tx_fifo #(.PAYLOAD_BITS(PB[0]), .FIFO_DEPTH(DP[0]), .DIV_BITS(16),
                   .PARITY_EN(PE[0]), .PARITY_ODD(PO[0]), .STOP_BITS(SB[0])) dut0 (
        .clk(clk), .reset(reset), .clk_div(clk_div), .uart_tx_en(tx_en),
        .uart_tx_data(tx_data[7:0]), .uart_tx_ready(o_ready[0]), .uart_tx_busy(o_busy[0]),
        .fifo_level(lvl0), .uart_txd(o_txd[0]));

    uart_tx_fifo #(.PAYLOAD_BITS(PB[1]), .FIFO_DEPTH(DP[1]), .DIV_BITS(16),
                   .PARITY_EN(PE[1]), .PARITY_ODD(PO[1]), .STOP_BITS(SB[1])) dut1 (
        .clk(clk), .reset(reset), .clk_div(clk_div), .uart_tx_en(tx_en),
        .uart_tx_data(tx_data[6:0]), .uart_tx_ready(o_ready[1]), .uart_tx_busy(o_busy[1]),
        .fifo_level(lvl1), .uart_txd(o_txd[1]));

    uart_tx_fifo #(.PAYLOAD_BITS(PB[2]), .FIFO_DEPTH(DP[2]), .DIV_BITS(16),
                   .PARITY_EN(PE[2]), .PARITY_ODD(PO[2]), .STOP_BITS(SB[2])) dut2 (
        .clk(clk), .reset(reset), .clk_div(clk_div), .uart_tx_en(tx_en),
        .uart_tx_data(tx_data[7:0]), .uart_tx_ready(o_ready[2]), .uart_tx_busy(o_busy[2]),
        .fifo_level(lvl2), .uart_txd(o_txd[2]));

    function automatic void mreset(int k);
        mq[k].delete();
        m_active[k] = 1'b0;
        m_t[k]      = 0;
        m_txd[k]    = 1'b1;
    endfunction

    // Builds the full bit sequence of one frame: start, data LSB first, parity, stops.
    function automatic void load_frame(int k, int unsigned d);
        int n;
        bit p;
        n = 0;
        p = 1'b0;
        m_bits[k][n] = 1'b0; n++;
        for (int i = 0; i < PB[k]; i++) begin
            m_bits[k][n] = d[i];
            p = p ^ d[i];
            n++;
        end
        if (PE[k] != 0) begin
            m_bits[k][n] = p ^ (PO[k] != 0);
            n++;
        end
        for (int s = 0; s < SB[k]; s++) begin
            m_bits[k][n] = 1'b1;
            n++;
        end
        m_nb[k]     = n;
        m_len[k]    = int'(clk_div) + 1;
        m_t[k]      = 0;
        m_active[k] = 1'b1;
    endfunction

    function automatic void mstep(int k);
        int pre;
        int unsigned d;
        pre = mq[k].size();
        m_txd[k] = m_active[k] ? m_bits[k][m_t[k] / m_len[k]] : 1'b1;
        if (m_active[k]) begin
            m_t[k]++;
            if (m_t[k] == m_nb[k] * m_len[k]) m_active[k] = 1'b0;
        end
        if (!m_active[k] && pre > 0) begin
            d = mq[k].pop_front();
            load_frame(k, d);
        end
        if (tx_en && pre < DP[k])
            mq[k].push_back(int'(tx_data) & ((1 << PB[k]) - 1));
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[dut%0d] t=%0t observed=%0d expected=%0d", tag, k, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] lv;
        for (int k = 0; k < NI; k++) begin
            lv = (k == 0) ? 32'(lvl0) : (k == 1) ? 32'(lvl1) : 32'(lvl2);
            chk("txd",   k, 32'(o_txd[k]),   32'(m_txd[k]));
            chk("level", k, lv,              32'(mq[k].size()));
            chk("ready", k, 32'(o_ready[k]), 32'(mq[k].size() < DP[k]));
            chk("busy",  k, 32'(o_busy[k]),  32'(mq[k].size() > 0 || m_active[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < NI; k++) begin
            if (reset) mreset(k);
            else       mstep(k);
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write1(input logic [8:0] d);
        tx_en   = 1'b1;
        tx_data = d;
        tick();
        tx_en   = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < NI; k++) mreset(k);
        run(3);
        reset = 1'b0;
        run(2);

        // 0x55 at 4 clocks per bit
        clk_div = 16'd3;
        write1(9'h055);
        run(60);

        // six writes on consecutive edges at 1 clock per bit
        clk_div = 16'd0;
        tx_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tx_data = 9'(8'hA0 + i);
            tick();
        end
        tx_en = 1'b0;
        run(90);

        // parity of 0x03 and a 7-bit all-ones payload
        clk_div = 16'd1;
        write1(9'h003);
        run(40);
        write1(9'h07F);
        run(40);

        // divisor change while the first of two frames is on the wire
        clk_div = 16'd3;
        write1(9'h0C3);
        write1(9'h13C);
        run(10);
        clk_div = 16'd7;
        run(160);

        // reset mid-frame with bytes still queued
        clk_div = 16'd2;
        write1(9'h0F0);
        write1(9'h011);
        write1(9'h022);
        run(14);
        #1 reset = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) mreset(k);
        check_all();
        run(2);
        reset = 1'b0;
        run(40);

        // random traffic, then drain
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) clk_div = 16'($urandom_range(0, 3));
            tx_en   = ($urandom_range(0, 2) == 0);
            tx_data = 9'($urandom);
            tick();
        end
        tx_en = 1'b0;
        run(500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
